db_req_issuer: RTL and testbench
================================

DB_REQ_ISSUER -- requirements
Module: db_req_issuer

Interface
REQ-001 SHALL have parameter KEY_SIZE, default 96, lookup key width sent to the database.
REQ-002 SHALL have parameter DEPTH, default 8, maximum outstanding requests; power of two, at least 2.
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles a head request waits for a response before being retired.
REQ-004 SHALL have port clk, input, 1 bit, the single clock domain.
REQ-005 SHALL have port rst, input, 1 bit, the reset: synchronous, active-high.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the request handshake.
REQ-007 SHALL have ports in_src_ip (input, 32), in_dst_ip (input, 32) and in_dst_port (input, 16), the packet tuple.
REQ-008 SHALL have ports in_op (input, 4), the database operation flag, and in_tag (input, 8), the caller's packet identifier.
REQ-009 SHALL have ports db_valid (output, 1), db_key (output, KEY_SIZE) and db_flag (output, 4), the request to the database.
REQ-010 SHALL have ports db_rsp_valid (input, 1) and db_rsp_flag (input, 4), the in-order database response.
REQ-011 SHALL have ports out_valid (output, 1), out_tag (output, 8), out_flag (output, 4) and out_timeout (output, 1), the decision output; out_* has no backpressure.
REQ-012 SHALL have port outstanding (output, log2(DEPTH)+1), the current tag FIFO occupancy.
REQ-013 SHALL have port err_unexpected (output, 1), a sticky flag for a response that matches no request.

Function
REQ-014 SHALL drive in_ready high exactly when (occupancy + drop credits) < DEPTH; in_ready is derived from registers only.
REQ-015 SHALL accept a request on any cycle where in_valid and in_ready are both high.
REQ-016 SHALL register db_key = {in_src_ip, in_dst_ip, in_dst_port, 16'h0000} and db_flag = in_op on accept, and pulse db_valid high for exactly one cycle on the following cycle.
REQ-017 SHALL support back-to-back accepts, one db_valid pulse per accepted request.
REQ-018 SHALL push in_tag into a DEPTH-entry circular tag FIFO in the accept cycle; read and write pointers wrap modulo DEPTH.
REQ-019 SHALL treat responses as strictly in order: db_rsp_valid with occupancy > 0 and drop credits = 0 pops the head tag.
REQ-020 SHALL, one cycle after a pop, assert out_valid for one cycle with out_tag = head tag, out_flag = db_rsp_flag and out_timeout = 0.
REQ-021 SHALL, when accept and pop occur in the same cycle, leave occupancy unchanged and keep the FIFO ordering correct.
REQ-022 SHALL, on db_rsp_valid with occupancy = 0 and drop credits = 0 (including the same cycle as an accept into an empty FIFO), discard the response, generate no out_valid, and set err_unexpected until reset.
REQ-023 SHALL keep db_key and db_flag at their last values while db_valid is low.

Reset
REQ-024 SHALL, while rst is high, clear db_valid, db_key, db_flag, out_valid, out_tag, out_flag, out_timeout, outstanding, err_unexpected, both FIFO pointers, drop credits and the watchdog, and hold in_ready low.
REQ-025 SHALL discard all in-flight requests when reset is asserted mid-operation; no out_valid is generated for them after reset.

Configuration
REQ-026 SHALL, with DB_TIMEOUT_EN defined, run a watchdog counter that clears whenever the head changes or the FIFO is empty and increments each cycle the FIFO is non-empty.
REQ-027 SHALL, with DB_TIMEOUT_EN defined, retire the head when the watchdog reaches TIMEOUT with no response that cycle: pop it, emit out_valid with out_flag = 4'h0 and out_timeout = 1, and increment drop credits, saturating at DEPTH.
REQ-028 SHALL, with DB_TIMEOUT_EN defined, give a response priority over a timeout in the same cycle.
REQ-029 SHALL, with DB_TIMEOUT_EN defined, discard any response that arrives while drop credits > 0, decrement the credits, and generate no out_valid.
REQ-030 SHALL, without DB_TIMEOUT_EN, omit the watchdog and drop credits (both treated as 0), tie out_timeout to 0, and wait for responses indefinitely.

Verification
REQ-031 Single request: src=0x0A000001, dst=0x0A000002, port=0x1F90, op=1, tag=0x11 -> db_valid the next cycle with db_key=0x0A0000010A0000021F900000; response flag=3 -> out_valid, tag 0x11, flag 3.
REQ-032 Fill: 8 back-to-back accepts, tags 0..7, no responses -> in_ready low after the 8th, outstanding=8; one response -> out_tag=0, in_ready high the following cycle.
REQ-033 Same-cycle accept and response with outstanding=3 -> outstanding stays 3, responses keep tag order.
REQ-034 Response with FIFO empty -> no out_valid, err_unexpected=1 and held until rst.
REQ-035 With DB_TIMEOUT_EN and TIMEOUT=4: one request, no response -> out_valid, out_timeout=1, out_flag=0 after 4 cycles; a late response -> discarded; the next request's response -> correctly matched.
REQ-036 Reset with 5 outstanding -> all outputs zero, no subsequent out_valid, and the first new request is tracked from an empty FIFO.

Source files
------------

// File: rtl/db_req_issuer_if.sv
// Request/response bus of the database request issuer.
// Handshake: a request transfers on any rising clk edge where in_valid and
// in_ready are both high; in_ready depends on issuer registers only.
// db_valid, db_rsp_valid and out_valid are single-cycle strobes with no
// backpressure. Responses on db_rsp_* return strictly in request order.
interface db_req_issuer_if #(
    parameter int KEY_SIZE = 96,
    parameter int DEPTH    = 8
);
    // request from the packet pipeline
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_src_ip;
    logic [31:0]              in_dst_ip;
    logic [15:0]              in_dst_port;
    logic [3:0]               in_op;
    logic [7:0]               in_tag;

    // request to the database
    logic                     db_valid;
    logic [KEY_SIZE-1:0]      db_key;
    logic [3:0]               db_flag;

    // in-order response from the database
    logic                     db_rsp_valid;
    logic [3:0]               db_rsp_flag;

    // decision output
    logic                     out_valid;
    logic [7:0]               out_tag;
    logic [3:0]               out_flag;
    logic                     out_timeout;

    // status
    logic [$clog2(DEPTH):0]   outstanding;
    logic                     err_unexpected;

    // environment side: issues requests, answers as the database, consumes decisions
    modport master (
        output in_valid, in_src_ip, in_dst_ip, in_dst_port, in_op, in_tag,
        output db_rsp_valid, db_rsp_flag,
        input  in_ready, db_valid, db_key, db_flag,
        input  out_valid, out_tag, out_flag, out_timeout,
        input  outstanding, err_unexpected
    );

    // issuer side
    modport slave (
        input  in_valid, in_src_ip, in_dst_ip, in_dst_port, in_op, in_tag,
        input  db_rsp_valid, db_rsp_flag,
        output in_ready, db_valid, db_key, db_flag,
        output out_valid, out_tag, out_flag, out_timeout,
        output outstanding, err_unexpected
    );
endinterface

// File: rtl/db_req_issuer.sv
// Database request issuer.
// Accepts packet tuples, forwards a lookup key to the database one cycle
// later, remembers each caller tag in a circular FIFO and pairs the in-order
// database responses with those tags on the decision output.
// Optional feature: define DB_TIMEOUT_EN to add a head-of-line watchdog that
// retires requests whose response never came; the late responses are then
// absorbed through drop credits. Without it, responses are awaited forever.
module db_req_issuer #(
    parameter int KEY_SIZE = 96,
    parameter int DEPTH    = 8,
    parameter int TIMEOUT  = 255
) (
    input logic          clk,
    input logic          rst,
    db_req_issuer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // FIFO state
    logic [7:0]    tag_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic [CW-1:0] occ_next;
    logic          in_ready_q;
    logic          ready_next;

    // drop credits: responses still owed for requests already retired
    logic [CW-1:0] credits;
    logic [CW-1:0] credits_next;

    // per-cycle events
    logic          accept;
    logic          occ_empty;
    logic          credit_zero;
    logic          rsp_pop;
    logic          rsp_unexp;
    logic          to_pop;
    logic          pop;

    // output registers
    logic                db_valid_q;
    logic [KEY_SIZE-1:0] db_key_q;
    logic [3:0]          db_flag_q;
    logic                out_valid_q;
    logic [7:0]          out_tag_q;
    logic [3:0]          out_flag_q;
    logic                err_q;

    // 96-bit tuple key, zero-extended or truncated to the configured key width
    logic [95:0]         tuple_key;

    assign tuple_key = {bus.in_src_ip, bus.in_dst_ip, bus.in_dst_port, 16'h0000};

    // Classify this cycle's request and response and derive next occupancy
    always_comb begin
        accept      = bus.in_valid && in_ready_q;
        occ_empty   = (occ == '0);
        credit_zero = (credits == '0);
        rsp_pop     = bus.db_rsp_valid && !occ_empty && credit_zero;
        rsp_unexp   = bus.db_rsp_valid && occ_empty && credit_zero;
        pop         = rsp_pop || to_pop;
        occ_next    = occ + CW'(accept) - CW'(pop);
        // occupancy plus credits may reach 2*DEPTH, so compare one bit wider
        ready_next  = ({1'b0, occ_next} + {1'b0, credits_next}) < (CW + 1)'(DEPTH);
    end

`ifdef DB_TIMEOUT_EN
    localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd;
    logic          rsp_drop;

    // Timeout retire and credit bookkeeping; a real response always wins
    always_comb begin
        rsp_drop     = bus.db_rsp_valid && !credit_zero;
        to_pop       = !occ_empty && !bus.db_rsp_valid && (wd >= WW'(TIMEOUT));
        credits_next = credits;
        if (to_pop && (credits != CW'(DEPTH))) begin
            credits_next = credits + 1'b1;
        end else if (rsp_drop) begin
            credits_next = credits - 1'b1;
        end
    end

    // Watchdog: restarts when the head changes or the FIFO is empty, saturates at TIMEOUT
    always_ff @(posedge clk) begin
        if (rst) begin
            wd      <= '0;
            credits <= '0;
        end else begin
            credits <= credits_next;
            if (pop || occ_empty) begin
                wd <= '0;
            end else if (wd < WW'(TIMEOUT)) begin
                wd <= wd + 1'b1;
            end
        end
    end

    logic out_timeout_q;

    // Timeout marker travels alongside out_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            out_timeout_q <= 1'b0;
        end else if (pop) begin
            out_timeout_q <= to_pop;
        end
    end

    assign bus.out_timeout = out_timeout_q;
`else
    assign to_pop          = 1'b0;
    assign credits         = '0;
    assign credits_next    = '0;
    assign bus.out_timeout = 1'b0;
`endif

    // Tag FIFO storage; pointers alone define validity, so no reset is needed
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= bus.in_tag;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ        <= occ_next;
            in_ready_q <= ready_next;
        end
    end

    // Database request: key and flag captured on accept, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            db_valid_q <= 1'b0;
            db_key_q   <= '0;
            db_flag_q  <= '0;
        end else begin
            db_valid_q <= accept;
            if (accept) begin
                db_key_q  <= KEY_SIZE'(tuple_key);
                db_flag_q <= bus.in_op;
            end
        end
    end

    // Decision output: one strobe per popped head tag
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_flag_q  <= '0;
        end else begin
            out_valid_q <= pop;
            if (pop) begin
                out_tag_q  <= tag_mem[rd_ptr];
                out_flag_q <= rsp_pop ? bus.db_rsp_flag : 4'h0;
            end
        end
    end

    // Sticky error for a response with nothing to match it
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (rsp_unexp) begin
            err_q <= 1'b1;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.db_valid       = db_valid_q;
    assign bus.db_key         = db_key_q;
    assign bus.db_flag        = db_flag_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_tag        = out_tag_q;
    assign bus.out_flag       = out_flag_q;
    assign bus.outstanding    = occ;
    assign bus.err_unexpected = err_q;

endmodule

// File: tb/tb_db_req_issuer.sv
// Bench for db_req_issuer: directed requests/responses, a reference tag queue
// and scoreboard queues checked by negedge monitors.
// Define DB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=4.
module tb_db_req_issuer;
    localparam int KEY_SIZE = 96;
    localparam int DEPTH    = 8;
`ifdef DB_TIMEOUT_EN
    localparam int TIMEOUT  = 4;
`else
    localparam int TIMEOUT  = 255;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    db_req_issuer_if #(.KEY_SIZE(KEY_SIZE), .DEPTH(DEPTH)) bus ();

    db_req_issuer #(
        .KEY_SIZE(KEY_SIZE),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // scoreboard state
    int checks   = 0;
    int failures = 0;
    logic [12:0] exp_q[$];     // {tag, flag, timeout}
    logic [99:0] db_exp_q[$];  // {key, flag}
    logic [7:0]  tag_q[$];     // reference tag FIFO
    int          credits_m = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid     = 1'b0;
        bus.in_src_ip    = '0;
        bus.in_dst_ip    = '0;
        bus.in_dst_port  = '0;
        bus.in_op        = '0;
        bus.in_tag       = '0;
        bus.db_rsp_valid = 1'b0;
        bus.db_rsp_flag  = '0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clock of stimulus (called at posedge+1): optional request, optional response
    task automatic drive_cycle(input bit req, input logic [31:0] src, input logic [31:0] dst,
                               input logic [15:0] port, input logic [3:0] op, input logic [7:0] tag,
                               input bit rsp, input logic [3:0] rflag);
        bit exp_ready;
        logic [7:0] head;
        exp_ready = (tag_q.size() + credits_m) < DEPTH;
        bus.in_valid     = req;
        bus.in_src_ip    = src;
        bus.in_dst_ip    = dst;
        bus.in_dst_port  = port;
        bus.in_op        = op;
        bus.in_tag       = tag;
        bus.db_rsp_valid = rsp;
        bus.db_rsp_flag  = rflag;
        if (req) check("in_ready_at_req", bus.in_ready, exp_ready);
        // response is matched against the FIFO as it was before this cycle's push
        if (rsp) begin
            if (credits_m > 0) begin
                credits_m--;
            end else if (tag_q.size() > 0) begin
                head = tag_q.pop_front();
                exp_q.push_back({head, rflag, 1'b0});
            end
        end
        if (req && exp_ready) begin
            db_exp_q.push_back({src, dst, port, 16'h0000, op});
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic send_req(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] port,
                            input logic [3:0] op, input logic [7:0] tag);
        drive_cycle(1'b1, src, dst, port, op, tag, 1'b0, 4'h0);
    endtask

    task automatic send_rsp(input logic [3:0] rflag);
        drive_cycle(1'b0, '0, '0, '0, '0, '0, 1'b1, rflag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},    bus.in_ready, 1'b0);
        check({tag, "_db_valid"},    bus.db_valid, 1'b0);
        check({tag, "_db_key"},      bus.db_key, '0);
        check({tag, "_db_flag"},     bus.db_flag, 4'h0);
        check({tag, "_out_valid"},   bus.out_valid, 1'b0);
        check({tag, "_out_tag"},     bus.out_tag, 8'h00);
        check({tag, "_out_flag"},    bus.out_flag, 4'h0);
        check({tag, "_out_timeout"}, bus.out_timeout, 1'b0);
        check({tag, "_outstanding"}, bus.outstanding, '0);
        check({tag, "_err"},         bus.err_unexpected, 1'b0);
    endtask

    // monitor: decision output against expected queue
    always @(negedge clk) begin
        logic [12:0] e;
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("out_valid_unexpected", {bus.out_tag, bus.out_flag, bus.out_timeout}, 13'h0);
            end else begin
                e = exp_q.pop_front();
                check("out_tag",     bus.out_tag,     e[12:5]);
                check("out_flag",    bus.out_flag,    e[4:1]);
                check("out_timeout", bus.out_timeout, e[0]);
            end
        end
    end

    // monitor: database request against expected queue
    always @(negedge clk) begin
        logic [99:0] d;
        if (bus.db_valid === 1'b1) begin
            if (db_exp_q.size() == 0) begin
                check("db_valid_unexpected", {bus.db_key, bus.db_flag}, 100'h0);
            end else begin
                d = db_exp_q.pop_front();
                check("db_key",  bus.db_key,  d[99:4]);
                check("db_flag", bus.db_flag, d[3:0]);
            end
        end
    end

    // hard stop if something hangs
    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        wait_cycles(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_cycles(1);
        check("ready_after_reset", bus.in_ready, 1'b1);

        // single request and matching response
        send_req(32'h0A000001, 32'h0A000002, 16'h1F90, 4'h1, 8'h11);
        check("db_valid_031", bus.db_valid, 1'b1);
        check("db_key_031", bus.db_key, 96'h0A0000010A0000021F900000);
        send_rsp(4'h3);
        check("outstanding_031", bus.outstanding, 4'd0);
        wait_cycles(3);
        check("db_valid_pulse", bus.db_valid, 1'b0);
        check("db_key_hold", bus.db_key, 96'h0A0000010A0000021F900000);
        check("db_flag_hold", bus.db_flag, 4'h1);

        // response with empty FIFO
        send_rsp(4'h7);
        check("err_set", bus.err_unexpected, 1'b1);
        wait_cycles(4);
        check("err_sticky", bus.err_unexpected, 1'b1);

`ifndef DB_TIMEOUT_EN
        // fill to DEPTH with no responses
        for (int i = 0; i < DEPTH; i++) begin
            send_req(32'hC0A80000 + i, 32'h08080808, 16'(1000 + i), 4'(i), 8'(i));
        end
        check("full_in_ready", bus.in_ready, 1'b0);
        check("full_outstanding", bus.outstanding, 4'd8);
        send_rsp(4'h5);
        check("after_pop_outstanding", bus.outstanding, 4'd7);
        check("after_pop_in_ready", bus.in_ready, 1'b1);
        for (int i = 1; i < DEPTH; i++) begin
            send_rsp(4'(i + 8));
        end
        check("drained_outstanding", bus.outstanding, 4'd0);
        wait_cycles(2);
`endif

        // simultaneous accept and response with three outstanding
        for (int i = 0; i < 3; i++) begin
            send_req(32'h01020300 + i, 32'h05060708, 16'h0050, 4'h2, 8'hA0 + 8'(i));
        end
        check("three_outstanding", bus.outstanding, 4'd3);
        drive_cycle(1'b1, 32'h01020303, 32'h05060708, 16'h0050, 4'h4, 8'hA3, 1'b1, 4'hC);
        check("same_cycle_outstanding", bus.outstanding, 4'd3);
        send_rsp(4'hD);
        send_rsp(4'hE);
        send_rsp(4'hF);
        check("same_cycle_drained", bus.outstanding, 4'd0);
        wait_cycles(2);

`ifdef DB_TIMEOUT_EN
        // head times out, its late response is absorbed, next request still pairs up
        send_req(32'h0B000001, 32'h0B000002, 16'h0035, 4'h6, 8'h77);
        begin
            logic [7:0] h;
            h = tag_q.pop_front();
            exp_q.push_back({h, 4'h0, 1'b1});
            credits_m++;
        end
        wait_cycles(10);
        check("timeout_outstanding", bus.outstanding, 4'd0);
        send_rsp(4'h6);
        wait_cycles(2);
        check("late_rsp_no_err", bus.err_unexpected, 1'b1);
        send_req(32'h0B000003, 32'h0B000004, 16'h0036, 4'h3, 8'h78);
        send_rsp(4'h2);
        wait_cycles(2);
`endif

        // reset with five in flight
        for (int i = 0; i < 5; i++) begin
            send_req(32'h0C000000 + i, 32'h0D000000, 16'h0101, 4'h8, 8'h30 + 8'(i));
        end
        check("five_outstanding", bus.outstanding, 4'd5);
        rst = 1'b1;
        tag_q.delete();
        credits_m = 0;
        wait_cycles(1);
        check_reset_outputs("midreset");
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(6);
        check("post_reset_outstanding", bus.outstanding, 4'd0);
        send_req(32'h0E000001, 32'h0E000002, 16'h0202, 4'h9, 8'h55);
        check("post_reset_one", bus.outstanding, 4'd1);
        send_rsp(4'h9);
        wait_cycles(3);
        check("post_reset_err", bus.err_unexpected, 1'b0);
        check("out_queue_empty", exp_q.size(), 0);
        check("db_queue_empty", db_exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
